// File: rtl/bp_update_queue.sv
// bp_update_queue: branch-prediction update queue.
// Fetch allocates entries (PC + 2-bit prediction) in program order, the
// resolution unit marks them resolved out of order by tag, and resolved
// entries drain in program order as one predictor update per cycle.
// A flush squashes every entry younger than flush_tag.
// Optional statistics counters are built when BPUQ_STATS_EN is defined;
// otherwise stat_updates/stat_mispredicts are tied to zero.
//
// Handshake: an allocation happens in a cycle where fetch_valid and
// fetch_ready are both high and no flush is present; fetch_tag names the
// entry taken by that allocation. The update port has no backpressure:
// update_valid is a one-cycle strobe per drained entry.
module bp_update_queue #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  input  logic [1:0]       fetch_pred,
  output logic             fetch_ready,
  output logic [IDX_W-1:0] fetch_tag,
  input  logic             resolve_valid,
  input  logic [IDX_W-1:0] resolve_tag,
  input  logic             resolve_taken,
  input  logic             flush_valid,
  input  logic [IDX_W-1:0] flush_tag,
  output logic             update_valid,
  output logic [31:0]      update_pc,
  output logic             update_taken,
  output logic [1:0]       update_pred,
  output logic             mispredict,
  output logic [31:0]      stat_updates,
  output logic [31:0]      stat_mispredicts
);

  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH);

  // Per-entry state
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] resolved_q;
  logic [DEPTH-1:0] taken_q;
  logic [31:0]      pc_q   [DEPTH];
  logic [1:0]       pred_q [DEPTH];

  // Circular buffer pointers
  logic [IDX_W-1:0] head_q;
  logic [IDX_W-1:0] tail_q;
  logic [IDX_W:0]   count_q;

  // Per-cycle events
  logic             alloc;
  logic             drain;
  logic             flush_ok;
  logic             resolve_ok;
  logic             mp_next;
  logic [IDX_W-1:0] flush_off;
  logic [IDX_W-1:0] resolve_off;
  logic [DEPTH-1:0] squash_mask;
  logic [DEPTH-1:0] drain_mask;
  logic [DEPTH-1:0] alloc_mask;
  logic [DEPTH-1:0] resolve_mask;
  logic [IDX_W:0]   count_next;
  logic [IDX_W-1:0] tail_next;

  assign fetch_ready = !rst && (count_q < DEPTH_CNT);
  assign fetch_tag   = tail_q;

  assign alloc    = fetch_valid && fetch_ready && !flush_valid;
  // Uses the registered resolved bit, so a resolve this cycle drains next cycle.
  assign drain    = valid_q[head_q] && resolved_q[head_q];
  assign flush_ok = flush_valid && valid_q[flush_tag];

  // Age of an entry = distance from head; valid entries are contiguous from head.
  assign flush_off   = flush_tag - head_q;
  assign resolve_off = resolve_tag - head_q;

  assign resolve_ok = resolve_valid && valid_q[resolve_tag] && !resolved_q[resolve_tag]
                      && !(flush_ok && (resolve_off > flush_off));
  assign mp_next    = resolve_ok && (resolve_taken != pred_q[resolve_tag][1]);

  // Per-entry masks for squash, drain, allocation and resolution
  always_comb begin
    squash_mask  = '0;
    drain_mask   = '0;
    alloc_mask   = '0;
    resolve_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash_mask[i]  = flush_ok && ((IDX_W'(i) - head_q) > flush_off);
      drain_mask[i]   = drain && (head_q == IDX_W'(i));
      alloc_mask[i]   = alloc && (tail_q == IDX_W'(i));
      resolve_mask[i] = resolve_ok && (resolve_tag == IDX_W'(i));
    end
  end

  // Next occupancy and tail; a flush rebuilds both from flush_tag
  always_comb begin
    count_next = count_q;
    tail_next  = tail_q;
    if (flush_ok) begin
      count_next = {1'b0, flush_off} + (IDX_W+1)'(1) - {{IDX_W{1'b0}}, drain};
      tail_next  = flush_tag + IDX_W'(1);
    end else begin
      count_next = count_q + {{IDX_W{1'b0}}, alloc} - {{IDX_W{1'b0}}, drain};
      if (alloc) tail_next = tail_q + IDX_W'(1);
    end
  end

  // Control state, pointers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      resolved_q   <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      update_valid <= 1'b0;
      update_pc    <= '0;
      update_taken <= 1'b0;
      update_pred  <= '0;
      mispredict   <= 1'b0;
    end else begin
      valid_q      <= (valid_q & ~squash_mask & ~drain_mask) | alloc_mask;
      resolved_q   <= (resolved_q & ~alloc_mask) | resolve_mask;
      head_q       <= drain ? head_q + IDX_W'(1) : head_q;
      tail_q       <= tail_next;
      count_q      <= count_next;
      update_valid <= drain;
      if (drain) begin
        update_pc    <= pc_q[head_q];
        update_taken <= taken_q[head_q];
        update_pred  <= pred_q[head_q];
      end
      mispredict <= mp_next;
    end
  end

  // Entry payload storage; contents are qualified by valid_q so need no reset
  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_q[tail_q]   <= fetch_pc;
      pred_q[tail_q] <= fetch_pred;
    end
    if (resolve_ok) taken_q[resolve_tag] <= resolve_taken;
  end

`ifdef BPUQ_STATS_EN
  logic [31:0] stat_upd_q;
  logic [31:0] stat_mp_q;

  // Wrapping event counters, advanced in step with the update/mispredict strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_upd_q <= '0;
      stat_mp_q  <= '0;
    end else begin
      if (drain)   stat_upd_q <= stat_upd_q + 32'd1;
      if (mp_next) stat_mp_q  <= stat_mp_q + 32'd1;
    end
  end

  assign stat_updates     = stat_upd_q;
  assign stat_mispredicts = stat_mp_q;
`else
  assign stat_updates     = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_bp_update_queue.sv
// Testbench for bp_update_queue: directed scenarios plus randomized traffic,
// checked against a program-order queue model with a timestamped scoreboard.
module tb_bp_update_queue;

  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             fetch_valid;
  logic [31:0]      fetch_pc;
  logic [1:0]       fetch_pred;
  logic             fetch_ready;
  logic [IDX_W-1:0] fetch_tag;
  logic             resolve_valid;
  logic [IDX_W-1:0] resolve_tag;
  logic             resolve_taken;
  logic             flush_valid;
  logic [IDX_W-1:0] flush_tag;
  logic             update_valid;
  logic [31:0]      update_pc;
  logic             update_taken;
  logic [1:0]       update_pred;
  logic             mispredict;
  logic [31:0]      stat_updates;
  logic [31:0]      stat_mispredicts;

  bp_update_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_pred(fetch_pred),
    .fetch_ready(fetch_ready), .fetch_tag(fetch_tag),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_taken(resolve_taken),
    .flush_valid(flush_valid), .flush_tag(flush_tag),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_pred(update_pred), .mispredict(mispredict),
    .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  typedef struct {
    int          tag;
    logic [31:0] pc;
    logic [1:0]  pred;
    bit          res;
    bit          taken;
  } ent_t;

  ent_t mq[$];      // in-flight branches, oldest first
  int   head_tag = 0;

  // ---------------- scoreboard ----------------
  logic [50:0] exp_q[$];  // {cycle stamp[15:0], pc, taken, pred}
  logic [15:0] mp_q[$];   // cycle stamps of expected mispredict pulses
  int tests = 0;
  int fails = 0;
  int upd_seen = 0;
  int mp_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against expectations due in this cycle
  always @(negedge clk) begin
    bit          eu;
    bit          em;
    logic [50:0] e;
    eu = (exp_q.size() > 0) && (exp_q[0][50:35] == cyc[15:0]);
    chk("update_valid", update_valid, eu);
    if (eu) begin
      e = exp_q.pop_front();
      if (update_valid) begin
        chk("update_pc", update_pc, e[34:3]);
        chk("update_taken", update_taken, e[2]);
        chk("update_pred", update_pred, e[1:0]);
      end
    end
    em = (mp_q.size() > 0) && (mp_q[0] == cyc[15:0]);
    chk("mispredict", mispredict, em);
    if (em) void'(mp_q.pop_front());
    if (update_valid) upd_seen++;
    if (mispredict) mp_seen++;
    if (rst) begin
      upd_seen = 0;
      mp_seen  = 0;
    end
  end

  // ---------------- driver ----------------
  // Drive one cycle of inputs, check the combinational outputs, advance the model.
  task automatic step(input bit r, input bit fv, input logic [31:0] pc, input logic [1:0] pr,
                      input bit rv, input int rt, input bit rk, input bit flv, input int ft);
    int   n;
    int   ridx;
    int   fidx;
    int   ntag;
    bit   drn;
    bit   fl_ok;
    ent_t e;
    logic [15:0] st;
    rst           = r;
    fetch_valid   = fv;
    fetch_pc      = pc;
    fetch_pred    = pr;
    resolve_valid = rv;
    resolve_tag   = rt[IDX_W-1:0];
    resolve_taken = rk;
    flush_valid   = flv;
    flush_tag     = ft[IDX_W-1:0];
    #1;
    n    = mq.size();
    ntag = (head_tag + n) % DEPTH;
    chk("fetch_ready", fetch_ready, !r && (n < DEPTH));
    chk("fetch_tag", fetch_tag, ntag);
    st = 16'(cyc + 1);
    if (r) begin
      mq.delete();
      head_tag = 0;
    end else begin
      ridx = -1;
      fidx = -1;
      for (int k = 0; k < n; k++) begin
        if (mq[k].tag == rt) ridx = k;
        if (mq[k].tag == ft) fidx = k;
      end
      drn   = (n > 0) && mq[0].res;
      fl_ok = flv && (fidx >= 0);
      if (rv && (ridx >= 0) && !mq[ridx].res && !(fl_ok && (ridx > fidx))) begin
        mq[ridx].res   = 1'b1;
        mq[ridx].taken = rk;
        if (rk != mq[ridx].pred[1]) mp_q.push_back(st);
      end
      if (fl_ok) while (mq.size() > fidx + 1) void'(mq.pop_back());
      if (drn) begin
        e = mq.pop_front();
        exp_q.push_back({st, e.pc, e.taken, e.pred});
        head_tag = (head_tag + 1) % DEPTH;
      end
      if (fv && !flv && (n < DEPTH)) begin
        e.tag = ntag; e.pc = pc; e.pred = pr; e.res = 1'b0; e.taken = 1'b0;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 32'h0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [1:0] pr);
    step(0, 1, pc, pr, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve(input int t, input bit k);
    step(0, 0, 32'h0, 2'b00, 1, t, k, 0, 0);
  endtask

  initial begin
    int          fprob;
    bit          r;
    bit          fv;
    bit          rv;
    bit          flv;
    int          rt;
    int          ft;
    logic [31:0] exp_stat_u;
    logic [31:0] exp_stat_m;
    rst = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; fetch_pred = '0;
    resolve_valid = 1'b0; resolve_tag = '0; resolve_taken = 1'b0;
    flush_valid = 1'b0; flush_tag = '0;
    @(posedge clk);
    #1;
    do_reset();
    idle();

    // Single branch, correct prediction
    fetch(32'h100, 2'b10);
    resolve(0, 1);
    repeat (3) idle();

    // Out-of-order resolution, in-order drain
    do_reset();
    for (int i = 0; i < 3; i++) fetch(32'h200 + 32'(4 * i), 2'(i));
    resolve(2, 1);
    resolve(1, 0);
    resolve(0, 1);
    repeat (4) idle();

    // Fill to full, overflow fetch ignored, drain re-opens
    do_reset();
    for (int i = 0; i < 9; i++) fetch(32'h300 + 32'(4 * i), 2'b11);
    resolve(0, 1);
    repeat (3) idle();

    // Flush beats fetch; squashed tags cannot be resolved
    do_reset();
    for (int i = 0; i < 5; i++) fetch(32'h400 + 32'(4 * i), 2'b00);
    step(0, 1, 32'h500, 2'b10, 0, 0, 0, 1, 1);
    fetch(32'h504, 2'b10);
    resolve(3, 1);
    resolve(4, 1);
    resolve(0, 0);
    resolve(1, 1);
    resolve(2, 0);
    repeat (4) idle();

    // Mispredict pulse, duplicate resolve ignored
    do_reset();
    fetch(32'h600, 2'b01);
    resolve(0, 1);
    resolve(0, 1);
    repeat (3) idle();

    // Reset with resolved but undrained entries
    do_reset();
    for (int i = 0; i < 3; i++) fetch(32'h700 + 32'(4 * i), 2'b10);
    resolve(2, 1);
    resolve(1, 1);
    resolve(0, 0);
    do_reset();
    idle();
    idle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      fprob = ((i / 200) % 2 == 1) ? 85 : 35;
      r   = ($urandom_range(0, 299) == 0);
      fv  = ($urandom_range(0, 99) < fprob);
      rv  = 1'b0;
      rt  = $urandom_range(0, DEPTH - 1);
      if ((mq.size() > 0) && ($urandom_range(0, 99) < 60)) begin
        rv = 1'b1;
        rt = mq[$urandom_range(0, mq.size() - 1)].tag;
      end else begin
        rv = ($urandom_range(0, 99) < 10);
      end
      flv = ($urandom_range(0, 99) < 4);
      ft  = $urandom_range(0, DEPTH - 1);
      if ((mq.size() > 0) && ($urandom_range(0, 99) < 80))
        ft = mq[$urandom_range(0, mq.size() - 1)].tag;
      step(r, fv, $urandom(), 2'($urandom_range(0, 3)), rv, rt, 1'($urandom_range(0, 1)), flv, ft);
    end

    // Resolve everything left so the queue empties
    for (int i = 0; i < 40; i++) begin
      rt = -1;
      for (int k = 0; k < mq.size(); k++) if (!mq[k].res && (rt < 0)) rt = mq[k].tag;
      if (rt >= 0) resolve(rt, 1'($urandom_range(0, 1)));
      else idle();
    end
    repeat (4) idle();
    #5;

    chk("exp_q_empty", exp_q.size(), 0);
    chk("mp_q_empty", mp_q.size(), 0);
`ifdef BPUQ_STATS_EN
    exp_stat_u = 32'(upd_seen);
    exp_stat_m = 32'(mp_seen);
`else
    exp_stat_u = 32'd0;
    exp_stat_m = 32'd0;
`endif
    chk("stat_updates", stat_updates, exp_stat_u);
    chk("stat_mispredicts", stat_mispredicts, exp_stat_m);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
